// File: rtl/layer_exec_pkg.sv
// Shared definitions for the layer execution sequencer: FSM state encoding,
// DMA buffer select codes and the byte-length arithmetic width/helper.
package layer_exec_pkg;

    localparam int LEN_W  = 32;
    localparam int DIM_W  = 16;
    localparam int ROWS_W = 8;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WT_REQ,
        ST_WT_WAIT,
        ST_IFM_REQ,
        ST_IFM_WAIT,
        ST_CMP_GO,
        ST_CMP_WAIT,
        ST_OFM_REQ,
        ST_OFM_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_WT  = 2'd0;
    localparam logic [1:0] SEL_IFM = 2'd1;
    localparam logic [1:0] SEL_OFM = 2'd2;

    // Byte-length product, deliberately truncated to LEN_W bits.
    function automatic len_t mul_len(input len_t a, input len_t b);
        return a * b;
    endfunction

endpackage

// File: rtl/layer_exec_sequencer_if.sv
// DMA request/completion and compute start/done handshakes seen by the
// sequencer. master = sequencer side, slave = DMA engine / compute array side.
interface layer_exec_sequencer_if #(
    parameter int AXI_ADDR_W = 32
) ();
    logic                  dma_req;
    logic                  dma_ack;
    logic                  dma_wr;
    logic [1:0]            dma_sel;
    logic [AXI_ADDR_W-1:0] dma_addr;
    logic [31:0]           dma_len;
    logic                  dma_done;
    logic                  cmp_start;
    logic [7:0]            cmp_rows;
    logic                  cmp_done;

    modport master (
        output dma_req, dma_wr, dma_sel, dma_addr, dma_len, cmp_start, cmp_rows,
        input  dma_ack, dma_done, cmp_done
    );

    modport slave (
        input  dma_req, dma_wr, dma_sel, dma_addr, dma_len, cmp_start, cmp_rows,
        output dma_ack, dma_done, cmp_done
    );
endinterface

// File: rtl/tile_addr_gen.sv
// Row-tile walker: holds the current output row and the IFM/OFM byte pointers,
// and derives the current tile height and its transfer lengths.
module tile_addr_gen
    import layer_exec_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int TILE_ROWS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DIM_W-1:0]      h,
    input  logic [AXI_ADDR_W-1:0] ifm_base,
    input  logic [AXI_ADDR_W-1:0] ofm_base,
    input  len_t                  in_row,
    input  len_t                  out_row,
    output logic [ROWS_W-1:0]     rows,
    output logic [AXI_ADDR_W-1:0] ifm_ptr,
    output logic [AXI_ADDR_W-1:0] ofm_ptr,
    output len_t                  ifm_len,
    output len_t                  ofm_len,
    output logic                  last
);
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] left;

    // row never passes h, so the remaining count cannot underflow
    assign left    = h - row;
    assign rows    = (left < DIM_W'(TILE_ROWS)) ? ROWS_W'(left) : ROWS_W'(TILE_ROWS);
    assign ifm_len = mul_len(LEN_W'(rows), in_row);
    assign ofm_len = mul_len(LEN_W'(rows), out_row);
    assign last    = ({1'b0, row} + (DIM_W+1)'(rows)) >= {1'b0, h};

    // Reset pointers at layer start, advance them by one tile per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row     <= '0;
            ifm_ptr <= '0;
            ofm_ptr <= '0;
        end else if (load) begin
            row     <= '0;
            ifm_ptr <= ifm_base;
            ofm_ptr <= ofm_base;
        end else if (step) begin
            row     <= row + DIM_W'(rows);
            ifm_ptr <= ifm_ptr + AXI_ADDR_W'(ifm_len);
            ofm_ptr <= ofm_ptr + AXI_ADDR_W'(ofm_len);
        end
    end

endmodule

// File: rtl/layer_exec_sequencer.sv
// Layer execution sequencer: accepts a layer_start from the layer controller,
// fetches weights once, then loops IFM read -> compute -> OFM write per row
// tile and pulses layer_done. Optional cycle counter: LAYER_PERF_CNT_EN.
module layer_exec_sequencer
    import layer_exec_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int TILE_ROWS  = 8,
    parameter int KSIZE      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  layer_start,
    input  logic [DIM_W-1:0]      H,
    input  logic [DIM_W-1:0]      W,
    input  logic [DIM_W-1:0]      Cin,
    input  logic [DIM_W-1:0]      Cout,
    input  logic [AXI_ADDR_W-1:0] weight_addr,
    input  logic [AXI_ADDR_W-1:0] ifm_addr,
    input  logic [AXI_ADDR_W-1:0] ofm_addr,
    output logic                  layer_done,
    output logic                  busy,
    output logic [31:0]           layer_cycles,
    layer_exec_sequencer_if.master bus
);
    localparam len_t KK = LEN_W'(KSIZE * KSIZE);

    state_t                state, state_nx;
    logic [DIM_W-1:0]      h_q, w_q, cin_q, cout_q;
    logic [AXI_ADDR_W-1:0] wt_base, ifm_base, ofm_base;
    len_t                  in_row, out_row, wlen;
    logic                  done_pend;
    logic                  start_acc, zero_dim, wait_hit;

    logic [ROWS_W-1:0]     rows;
    logic [AXI_ADDR_W-1:0] ifm_ptr, ofm_ptr;
    len_t                  ifm_len, ofm_len;
    logic                  last;

    logic                  req_c, wr_c, cmp_start_c;
    logic [1:0]            sel_c;
    logic [AXI_ADDR_W-1:0] addr_c;
    len_t                  len_c;
    logic [ROWS_W-1:0]     cmp_rows_c;

    assign start_acc = layer_start && (state == ST_IDLE);
    assign zero_dim  = (h_q == '0) || (w_q == '0) || (cin_q == '0) || (cout_q == '0);
    // a done that arrived together with the ack is replayed in the WAIT cycle
    assign wait_hit  = bus.dma_done || done_pend;

    tile_addr_gen #(
        .AXI_ADDR_W (AXI_ADDR_W),
        .TILE_ROWS  (TILE_ROWS)
    ) u_tile (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_LATCH),
        .step     (state == ST_NEXT),
        .h        (h_q),
        .ifm_base (ifm_base),
        .ofm_base (ofm_base),
        .in_row   (in_row),
        .out_row  (out_row),
        .rows     (rows),
        .ifm_ptr  (ifm_ptr),
        .ofm_ptr  (ofm_ptr),
        .ifm_len  (ifm_len),
        .ofm_len  (ofm_len),
        .last     (last)
    );

    // Capture the layer config on an accepted start; derive row/weight sizes in LATCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            w_q      <= '0;
            cin_q    <= '0;
            cout_q   <= '0;
            wt_base  <= '0;
            ifm_base <= '0;
            ofm_base <= '0;
            in_row   <= '0;
            out_row  <= '0;
            wlen     <= '0;
        end else if (start_acc) begin
            h_q      <= H;
            w_q      <= W;
            cin_q    <= Cin;
            cout_q   <= Cout;
            wt_base  <= weight_addr;
            ifm_base <= ifm_addr;
            ofm_base <= ofm_addr;
        end else if (state == ST_LATCH) begin
            in_row   <= mul_len(LEN_W'(w_q), LEN_W'(cin_q));
            out_row  <= mul_len(LEN_W'(w_q), LEN_W'(cout_q));
            wlen     <= mul_len(mul_len(LEN_W'(cin_q), LEN_W'(cout_q)), KK);
        end
    end

    // Remember an ack+done coincidence so the following WAIT cycle sees it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_pend <= 1'b0;
        else     done_pend <= req_c && bus.dma_ack && bus.dma_done;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx    = state;
        req_c       = 1'b0;
        wr_c        = 1'b0;
        sel_c       = SEL_WT;
        addr_c      = '0;
        len_c       = '0;
        cmp_start_c = 1'b0;
        cmp_rows_c  = '0;
        case (state)
            ST_IDLE:     if (layer_start) state_nx = ST_LATCH;
            ST_LATCH:    state_nx = zero_dim ? ST_DONE : ST_WT_REQ;
            ST_WT_REQ: begin
                req_c  = 1'b1;
                sel_c  = SEL_WT;
                addr_c = wt_base;
                len_c  = wlen;
                if (bus.dma_ack) state_nx = ST_WT_WAIT;
            end
            ST_WT_WAIT:  if (wait_hit) state_nx = ST_IFM_REQ;
            ST_IFM_REQ: begin
                req_c  = 1'b1;
                sel_c  = SEL_IFM;
                addr_c = ifm_ptr;
                len_c  = ifm_len;
                if (bus.dma_ack) state_nx = ST_IFM_WAIT;
            end
            ST_IFM_WAIT: if (wait_hit) state_nx = ST_CMP_GO;
            ST_CMP_GO: begin
                // cmp_done in this cycle belongs to nobody and is dropped
                cmp_start_c = 1'b1;
                cmp_rows_c  = rows;
                state_nx    = ST_CMP_WAIT;
            end
            ST_CMP_WAIT: begin
                cmp_rows_c = rows;
                if (bus.cmp_done) state_nx = ST_OFM_REQ;
            end
            ST_OFM_REQ: begin
                req_c  = 1'b1;
                wr_c   = 1'b1;
                sel_c  = SEL_OFM;
                addr_c = ofm_ptr;
                len_c  = ofm_len;
                if (bus.dma_ack) state_nx = ST_OFM_WAIT;
            end
            ST_OFM_WAIT: if (wait_hit) state_nx = ST_NEXT;
            ST_NEXT:     state_nx = last ? ST_DONE : ST_IFM_REQ;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    assign bus.dma_req   = req_c;
    assign bus.dma_wr    = wr_c;
    assign bus.dma_sel   = sel_c;
    assign bus.dma_addr  = addr_c;
    assign bus.dma_len   = len_c;
    assign bus.cmp_start = cmp_start_c;
    assign bus.cmp_rows  = cmp_rows_c;

    assign layer_done = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

`ifdef LAYER_PERF_CNT_EN
    logic [31:0] cyc_cnt;

    // Count busy cycles of the current layer; value holds after layer_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cyc_cnt <= '0;
        else if (start_acc) cyc_cnt <= '0;
        else if (busy)      cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign layer_cycles = cyc_cnt;
`else
    assign layer_cycles = '0;
`endif

endmodule

// File: doc/layer_exec_sequencer.md
Name: layer_exec_sequencer

Overview:
- Responder side of the layer_start/layer_done handshake issued by the per-layer controller.
- Latches one layer's config (H, W, Cin, Cout, weight/ifm/ofm base addresses) and sequences DMA transfers: weights once per layer, then IFM read → compute → OFM write per row tile.
- Pulses layer_done when the last OFM tile has been written.
- Sits between the layer controller, the DMA engine and the compute array.

Parameters:
- AXI_ADDR_W, 32, DMA address width.
- TILE_ROWS, 8, output rows per tile (1..255).
- KSIZE, 3, kernel side; weight bytes = Cin*Cout*KSIZE*KSIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- layer_start  in  1  one-cycle start pulse.
- H, W, Cin, Cout  in  16 each  layer geometry; sampled on accepted layer_start.
- weight_addr, ifm_addr, ofm_addr  in  AXI_ADDR_W each  byte base addresses.
- layer_done  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted start until the layer_done cycle inclusive.
- dma_req  out  1  request valid; held until dma_ack.
- dma_ack  in  1  request accepted.
- dma_wr  out  1  0 = read to on-chip buffer, 1 = write from buffer.
- dma_sel  out  2  buffer: 0 = weights, 1 = IFM, 2 = OFM.
- dma_addr  out  AXI_ADDR_W  transfer byte address.
- dma_len  out  32  transfer byte count.
- dma_done  in  1  pulse when the accepted transfer completes.
- cmp_start  out  1  one-cycle compute pulse.
- cmp_rows  out  8  rows in the current tile.
- cmp_done  in  1  compute-finished pulse.
- layer_cycles  out  32  see Optional Feature.

Behaviour:
- Reset: all outputs 0; state IDLE; all internal registers 0. Reset mid-layer aborts immediately. No layer_done is generated for the aborted layer.
- Accept rule: layer_start is accepted only in IDLE. It is ignored while busy.
- Arithmetic (LATCH state): all 32-bit, results truncated modulo 2^32.
  - in_row = W*Cin
  - out_row = W*Cout
  - wlen = Cin*Cout*KSIZE*KSIZE
  - Address pointers wrap modulo 2^AXI_ADDR_W.
- States and transitions:
  - IDLE: go to LATCH on an accepted start.
  - LATCH (1 cycle): if any of H/W/Cin/Cout is 0, go to DONE; otherwise go to WT_REQ, with row=0, ifm_ptr=ifm_addr, ofm_ptr=ofm_addr.
  - WT_REQ: dma_req=1, wr=0, sel=0, addr=weight_addr, len=wlen. On dma_ack, go to WT_WAIT.
  - WT_WAIT: on dma_done, go to IFM_REQ.
  - IFM_REQ: rows = min(TILE_ROWS, H-row); addr=ifm_ptr, len=rows*in_row, sel=1. On ack, go to IFM_WAIT. On dma_done, go to CMP.
  - CMP: cmp_start pulses on the first cycle with cmp_rows=rows, then wait for cmp_done. A cmp_done arriving in the same cycle as cmp_start is ignored. Then go to OFM_REQ.
  - OFM_REQ: wr=1, sel=2, addr=ofm_ptr, len=rows*out_row. On ack, go to OFM_WAIT. On dma_done, go to NEXT.
  - NEXT: row += rows; ifm_ptr += rows*in_row; ofm_ptr += rows*out_row. If row ≥ H, go to DONE; otherwise go to IFM_REQ.
  - DONE: layer_done=1 for one cycle, then IDLE.
- Latency:
  - layer_start in cycle 0 → dma_req high in cycle 2.
  - Final OFM dma_done in cycle n → layer_done in cycle n+2.
  - Zero-size layer: layer_done in cycle 2.
- dma_req, dma_addr, dma_len, dma_wr and dma_sel stay stable while dma_req=1 and dma_ack=0. dma_req drops the cycle after the ack.
- dma_done or cmp_done outside its wait state is ignored.
- dma_ack and dma_done high in the same cycle while in a REQ state: treat as ack then done. Proceed as if the done arrived in the following WAIT cycle, with no lost event.

Optional Feature:
- Macro: LAYER_PERF_CNT_EN.
- Defined: layer_cycles clears on an accepted start, increments every cycle while busy, and holds its value after layer_done until the next start.
- Undefined: layer_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package layer_exec_pkg: state encoding, dma_sel constants (SEL_WT, SEL_IFM, SEL_OFM), and byte-length function widths.
- One natural sub-module, tile_addr_gen:
  - Holds row, ifm_ptr and ofm_ptr.
  - Computes rows and lengths.
  - Inputs: load and step strobes.

Test Plan:
- H=224, W=224, Cin=3, Cout=16, bases 0/0x1000/0x80000000:
  - Weight request len=432.
  - 28 IFM reads of len 5376; 2nd addr=0x1000+5376.
  - OFM len=28672; 2nd addr=0x80007000.
  - One layer_done.
- H=10, TILE_ROWS=8 → two tiles: cmp_rows 8 then 2; second IFM len=2*W*Cin.
- Cin=0 → no dma_req, no cmp_start; layer_done in cycle 2; busy high in cycles 1–2.
- Second layer_start during CMP → ignored; one layer_done; next start after IDLE is accepted with new config.
- dma_ack delayed 5 cycles → req, addr and len held stable. Ack and done in the same cycle → advances correctly.
- rst pulse during OFM_WAIT → all outputs 0 next cycle, no layer_done. New start runs cleanly. With LAYER_PERF_CNT_EN, layer_cycles equals the busy duration.
